// File: rtl/xmem_rd_stage_pkg.sv
// Shared definitions for the xmem read-issue stage: default widths,
// the 2-bit FSM state encoding and the minimum RUN dwell before DRAIN.
// Optional feature macro used by the top: XMEMRD_BITREV_EN.
package xmem_rd_stage_pkg;

    localparam int XMEMRD_MEM_ADDR_W = 10;

    localparam int XMEMRD_DATA_W = 32;

    localparam logic [1:0] XMEMRD_IDLE  = 2'd0;
    localparam logic [1:0] XMEMRD_RUN   = 2'd1;
    localparam logic [1:0] XMEMRD_DRAIN = 2'd2;
    localparam logic [1:0] XMEMRD_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = XMEMRD_IDLE,
        S_RUN   = XMEMRD_RUN,
        S_DRAIN = XMEMRD_DRAIN,
        S_DONE  = XMEMRD_DONE
    } xmemrd_state_t;

    // The generator's done level is stale for this many RUN cycles.
    localparam logic [1:0] XMEMRD_MIN_RUN = 2'd2;

endpackage

// File: rtl/xmem_rd_stage_pipe.sv
// xmemrd_pipe: valid-bit shift register tracking reads in flight.
// Ports: clk, rst (sync, active-low), flush, push (RAM enable),
//        tap (valid aligned with RAM data), valid (aligned with
//        registered data), empty (no word left that will reach tap).
module xmemrd_pipe
    import xmem_rd_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    output logic tap,
    output logic valid,
    output logic empty
);

    logic [DEPTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], push};
        end
    end

    assign tap   = stage[DEPTH-2];
    assign valid = stage[DEPTH-1];

    // The output stage is excluded: a word sitting there is already
    // delivered, so DONE can be entered on the same edge it leaves.
    assign empty = !push && (stage[DEPTH-2:0] == '0);

endmodule

// File: rtl/xmem_rd_stage.sv
// xmem_rd_stage: issues generator addresses to a synchronous RAM,
// realigns read data with a valid strobe, counts words, signals done.
// Ports: clk, rst (sync, active-low), run, addr_in, mem_en_in, done_in,
//        [bitrev], mem_addr, mem_en, mem_data, data_out, data_valid,
//        count, done. Define XMEMRD_BITREV_EN for bit-reversed addressing.
module xmem_rd_stage
    import xmem_rd_stage_pkg::*;
#(
    parameter int MEM_ADDR_W = XMEMRD_MEM_ADDR_W,
    parameter int DATA_W     = XMEMRD_DATA_W,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [MEM_ADDR_W-1:0] addr_in,
    input  logic                  mem_en_in,
    input  logic                  done_in,
`ifdef XMEMRD_BITREV_EN
    input  logic                  bitrev,
`endif
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_en,
    input  logic [DATA_W-1:0]     mem_data,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_valid,
    output logic [MEM_ADDR_W:0]   count,
    output logic                  done
);

    xmemrd_state_t         state;
    logic [1:0]            run_age;
    logic [MEM_ADDR_W-1:0] addr_next;
    logic                  word_in;
    logic                  pipe_empty;

`ifdef XMEMRD_BITREV_EN
    logic [MEM_ADDR_W-1:0] addr_rev;

    always_comb begin
        addr_rev = '0;
        for (int i = 0; i < MEM_ADDR_W; i++) begin
            addr_rev[i] = addr_in[MEM_ADDR_W-1-i];
        end
    end

    assign addr_next = bitrev ? addr_rev : addr_in;
`else
    assign addr_next = addr_in;
`endif

    // Stage 0 is fed by the registered enable, so tap lines up with
    // mem_data RD_LAT cycles later and valid one cycle after that.
    xmemrd_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .flush (run),
        .push  (mem_en),
        .tap   (word_in),
        .valid (data_valid),
        .empty (pipe_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            run_age  <= '0;
            mem_addr <= '0;
            mem_en   <= 1'b0;
            data_out <= '0;
            count    <= '0;
            done     <= 1'b1;
        end else begin
            if (word_in && !run) begin
                data_out <= mem_data;
            end

            // Counted on the edge that raises data_valid, so count
            // already includes the word currently on data_out.
            if (run) begin
                count <= '0;
            end else if (word_in && (count != '1)) begin
                count <= count + 1'b1;
            end

            if (run) begin
                state   <= S_RUN;
                run_age <= '0;
                mem_en  <= 1'b0;
                done    <= 1'b0;
            end else begin
                unique case (state)
                    S_RUN: begin
                        mem_en <= mem_en_in;
                        if (mem_en_in) begin
                            mem_addr <= addr_next;
                        end
                        if (run_age != XMEMRD_MIN_RUN) begin
                            run_age <= run_age + 1'b1;
                        end
                        if (done_in && !mem_en_in &&
                            (run_age == XMEMRD_MIN_RUN)) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        mem_en <= 1'b0;
                        if (pipe_empty) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        mem_en <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                    S_IDLE: begin
                        mem_en <= 1'b0;
                        done   <= 1'b1;
                    end
                    default: begin
                        mem_en <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/xmem_rd_stage.md
# xmem_rd_stage

Read-issue stage placed directly downstream of the two-level address generator (addrgenA/addrgenB pair) in a Versat memory unit. It consumes the generator's `addr`/`mem_en`/`done` stream, drives the synchronous RAM read port, realigns returned data with a valid strobe, counts delivered words and raises `done` only after the last word has left the pipeline. Optional bit-reversed addressing supports FFT-style access.

## Interface
Parameters:
- `MEM_ADDR_W`, default `` `MEM_ADDR_W ``, address width.
- `DATA_W`, default `` `DATA_W ``, RAM data width.
- `RD_LAT`, default 1, RAM read latency in cycles (legal 1..4).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `run`  in  1  start pulse, same pulse that starts the address generator.
- `addr_in`  in  MEM_ADDR_W  generator address.
- `mem_en_in`  in  1  generator read enable.
- `done_in`  in  1  generator done level.
- `bitrev`  in  1  reverse address bits (present only with `XMEMRD_BITREV_EN`).
- `mem_addr`  out  MEM_ADDR_W  RAM address, registered.
- `mem_en`  out  1  RAM enable, registered.
- `mem_data`  in  DATA_W  RAM read data, valid RD_LAT cycles after `mem_en`.
- `data_out`  out  DATA_W  registered read data.
- `data_valid`  out  1  `data_out` holds a new word this cycle.
- `count`  out  MEM_ADDR_W+1  words delivered since last `run`, saturating at all-ones.
- `done`  out  1  stage idle and drained.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset (`rst`=0 at an edge): state IDLE; `mem_addr`=0, `mem_en`=0, `data_out`=0, `data_valid`=0, `count`=0, `done`=1; valid pipeline cleared.
- `run`=1 in any state: next state RUN, `count`←0, valid pipeline flushed (in-flight words never raise `data_valid`), `done`←0. `mem_en_in` sampled in the `run` cycle is discarded.
- RUN: each cycle with `mem_en_in`=1 registers `addr_in` (bit-reversed if enabled and `bitrev`=1) into `mem_addr` and sets `mem_en`=1; otherwise `mem_en`=0 and `mem_addr` holds.
- RUN→DRAIN when `done_in`=1 and `mem_en_in`=0, provided at least 2 cycles have elapsed in RUN (masks the generator's stale done level after `run`).
- DRAIN: no new reads issued; →DONE when valid pipeline empty.
- DONE: `done`=1; →IDLE next cycle. IDLE holds `done`=1.
- `count` increments on every `data_valid`; saturates, never wraps.
- `data_out` holds its last value when `data_valid`=0.

## Timing
- `mem_en_in` at cycle t → `mem_en`/`mem_addr` at t+1 → `mem_data` at t+1+RD_LAT → `data_out`/`data_valid` at t+2+RD_LAT. Total latency RD_LAT+2.
- Full throughput: one word per cycle, back-to-back, no bubbles inserted.
- `done` rises 1 cycle after the last `data_valid` at the earliest (DONE entry).
- `run` mid-operation: takes effect at the next edge; words issued before it are suppressed.
- Reset mid-operation overrides `run`.

## Configuration
- `XMEMRD_BITREV_EN` defined: `bitrev` port exists; when 1, `mem_addr[i]`=`addr_in[MEM_ADDR_W-1-i]` for all i.
- Undefined: `bitrev` port absent; addresses pass unchanged.

## Structure
- State encoding constants (`XMEMRD_IDLE`..`XMEMRD_DONE`, 2 bits) live in `xversat.vh`.
- One sub-module: `xmemrd_pipe`, an RD_LAT+1-deep valid shift register with synchronous flush and an `empty` output.

## Test plan
- Reset, then idle 5 cycles → `done`=1, `mem_en`=0, `count`=0.
- `run`, stream addresses 0..7 with `mem_en_in`=1, RD_LAT=1, RAM[a]=a+100 → `data_out` 100..107 consecutive, first at 3 cycles after first `mem_en_in`; `count`=8; `done` rises after word 107.
- Gaps: `mem_en_in` pattern 1,0,1,1,0,1 → `data_valid` reproduces pattern delayed RD_LAT+2; `count`=4.
- `run` reissued while 3 words in flight → none appear on `data_valid`; `count`=0 then restarts.
- `done_in` held 1 during first 2 RUN cycles → no DRAIN entry; `done` stays 0.
- With `XMEMRD_BITREV_EN`, MEM_ADDR_W=4, `bitrev`=1, `addr_in`=4'b0001 → `mem_addr`=4'b1000.
